// File: rtl/team_09_wbm_arbiter.sv
// team_09_wbm_arbiter
// Shares the single Wishbone classic master port among N_REQ requesters.
// Round-robin arbitration, one single-beat transfer at a time.
// The FSM runs IDLE -> BUS -> DONE -> IDLE.
// Optional macro WBM_TIMEOUT_EN adds an ACK timeout in BUS. The timeout ends the
// transfer with err_o=1. When the macro is not defined, BUS waits for ACK_I forever
// and err_o is tied low.
module team_09_wbm_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ-1:0]     req_we_i,
    input  logic [32*N_REQ-1:0]  req_adr_i,
    input  logic [32*N_REQ-1:0]  req_dat_i,
    input  logic [4*N_REQ-1:0]   req_sel_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [N_REQ-1:0]     done_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [31:0]          ADR_O,
    output logic [31:0]          DAT_O,
    output logic [3:0]           SEL_O,
    output logic                 WE_O,
    output logic                 STB_O,
    output logic                 CYC_O,
    input  logic [31:0]          DAT_I,
    input  logic                 ACK_I
);

    localparam int PTR_W = $clog2(N_REQ);

    // Elaboration-time range check on the configuration
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("team_09_wbm_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   rr_reg, rr_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic [31:0]        adr_reg, adr_next;
    logic [31:0]        dat_reg, dat_next;
    logic [3:0]         sel_reg, sel_next;
    logic               we_reg, we_next;
    logic               cyc_reg, cyc_next;
`ifdef WBM_TIMEOUT_EN
    logic [7:0]         wait_reg, wait_next;
    logic               err_reg, err_next;
`endif

    // Per-requester views of the packed payload buses
    logic [31:0] adr_arr [N_REQ];
    logic [31:0] dat_arr [N_REQ];
    logic [3:0]  sel_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign adr_arr[gi] = req_adr_i[32*gi +: 32];
        assign dat_arr[gi] = req_dat_i[32*gi +: 32];
        assign sel_arr[gi] = req_sel_i[4*gi +: 4];
    end

    // Round-robin pick: the first set request at or after rr_reg, wrapping modulo N_REQ
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand_ptr;
    int               cand;

    always_comb begin
        win_idx  = '0;
        cand_ptr = '0;
        cand     = 0;
        // Walk from the farthest offset down so that the nearest match is written last
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = int'(rr_reg) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_ptr = PTR_W'(cand);
            if (req_i[cand_ptr]) begin
                win_idx = cand_ptr;
            end
        end
    end

    // Pointer to the requester after the current owner; loaded when a transfer ends
    logic [PTR_W-1:0] rr_after_owner;
    assign rr_after_owner = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    // Next-state logic and next values for the registered outputs
    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        owner_next = owner_reg;
        gnt_next   = gnt_reg;
        done_next  = '0;
        rdata_next = rdata_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        sel_next   = sel_reg;
        we_next    = we_reg;
        cyc_next   = cyc_reg;
`ifdef WBM_TIMEOUT_EN
        wait_next  = wait_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|req_i) begin
                    state_next = ST_BUS;
                    owner_next = win_idx;
                    gnt_next   = N_REQ'(1) << win_idx;
                    adr_next   = adr_arr[win_idx];
                    dat_next   = dat_arr[win_idx];
                    sel_next   = sel_arr[win_idx];
                    we_next    = req_we_i[win_idx];
                    cyc_next   = 1'b1;
`ifdef WBM_TIMEOUT_EN
                    wait_next  = '0;
`endif
                end
            end
            ST_BUS: begin
                if (ACK_I) begin
                    // Normal completion; an ACK in the timeout cycle still wins
                    state_next = ST_DONE;
                    cyc_next   = 1'b0;
                    done_next  = gnt_reg;
                    rr_next    = rr_after_owner;
                    if (!we_reg) begin
                        rdata_next = DAT_I;
                    end
`ifdef WBM_TIMEOUT_EN
                    err_next   = 1'b0;
                end else if (wait_reg == 8'(TIMEOUT_CYC - 1)) begin
                    state_next = ST_DONE;
                    cyc_next   = 1'b0;
                    done_next  = gnt_reg;
                    rr_next    = rr_after_owner;
                    rdata_next = '0;
                    err_next   = 1'b1;
                end else begin
                    wait_next  = wait_reg + 8'd1;
`endif
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            rr_reg    <= '0;
            owner_reg <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            rdata_reg <= '0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            cyc_reg   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            wait_reg  <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            owner_reg <= owner_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            rdata_reg <= rdata_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            cyc_reg   <= cyc_next;
`ifdef WBM_TIMEOUT_EN
            wait_reg  <= wait_next;
            err_reg   <= err_next;
`endif
        end
    end

    assign gnt_o   = gnt_reg;
    assign done_o  = done_reg;
    assign rdata_o = rdata_reg;
    assign ADR_O   = adr_reg;
    assign DAT_O   = dat_reg;
    assign SEL_O   = sel_reg;
    assign WE_O    = we_reg;
    assign STB_O   = cyc_reg;
    assign CYC_O   = cyc_reg;
`ifdef WBM_TIMEOUT_EN
    assign err_o   = err_reg;
`else
    assign err_o   = 1'b0;
`endif

endmodule
